miriscv_lsu_obi: RTL and testbench
==================================

Name: miriscv_lsu_obi

Overview:
Parametrised load/store unit that replaces the single-cycle combinational LSU. It connects the core's memory stage to a data memory with a request/grant/response handshake (req/gnt, rvalid), supporting variable memory latency. It generalises datapath width (XLEN 32/64), performs lane alignment, sign/zero extension and byte-enable generation, and detects misaligned or illegal accesses. It stalls the core from request acceptance until the registered result is available.

Parameters:
XLEN, 32, data/register width; legal values 32 or 64.
ADDR_W, 32, address width.
BE_W, XLEN/8, byte-enable width; derived, not overridable.

Ports:
clk_i  in  1  clock
arstn_i  in  1  reset, synchronous, active-low
lsu_req_i  in  1  core requests a memory access; held stable while core_stall_o=1
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  3  funct3 code (LDST_B/H/W/D/BU/HU/WU)
lsu_addr_i  in  ADDR_W  byte address
lsu_data_i  in  XLEN  store data, LSB-aligned
lsu_data_o  out  XLEN  load result, extended and registered
core_stall_o  out  1  core must hold its memory stage
lsu_exc_o  out  1  exception pulse, valid in the completion cycle
lsu_exc_cause_o  out  2  01 misaligned, 10 illegal size, 11 bus error
data_req_o  out  1  memory request
data_gnt_i  in  1  memory accepts the request
data_we_o  out  1  write enable
data_be_o  out  BE_W  byte enables
data_addr_o  out  ADDR_W  address, aligned down to the XLEN/8 boundary
data_wdata_o  out  XLEN  store data, replicated across lanes
data_rvalid_i  in  1  response valid; arrives for both loads and stores
data_rdata_i  in  XLEN  read data
data_err_i  in  1  bus error, qualified by data_rvalid_i

Behaviour:
- Reset (arstn_i=0 at a clk_i edge):
  - The FSM goes to IDLE.
  - Every output register goes to 0, including lsu_data_o, lsu_exc_o, lsu_exc_cause_o and the request holding registers.
  - Combinational outputs evaluate to 0 in IDLE with lsu_req_i=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Idle when lsu_req_i=0: no outputs asserted.
  - Access check, combinational:
    - Illegal size: code 7, or 3/6 when XLEN=32.
    - Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
  - Illegal or misaligned: go to DONE with the exception latched. No data_req_o. core_stall_o=1 this cycle.
  - Legal:
    - data_req_o=1, driven directly from the inputs.
    - Address, we, size, offset and wdata are latched.
    - data_gnt_i=1: go to WAIT. Otherwise go to REQ.
    - core_stall_o=1.
- REQ:
  - data_req_o=1 and all data_* outputs are driven from the latched registers; they are stable until grant.
  - On data_gnt_i, go to WAIT.
- WAIT:
  - data_req_o=0.
  - On data_rvalid_i, capture the extended load data into lsu_data_o (stores capture 0) and go to DONE.
  - If data_err_i=1, lsu_data_o=0 and cause is 11.
  - rvalid in the same cycle as gnt is not legal for the memory; the LSU ignores it.
- DONE:
  - core_stall_o=0, lsu_data_o valid, and lsu_exc_o/cause valid for exactly this cycle.
  - lsu_req_i is ignored: it still belongs to the completing instruction.
  - Return to IDLE.
- core_stall_o = lsu_req_i in IDLE, 1 in REQ/WAIT, 0 in DONE.
- Latency:
  - Zero-wait memory (gnt in cycle 0, rvalid in cycle 1): DONE in cycle 2, so the core stalls 2 cycles.
  - Exceptions: the core stalls 1 cycle.
- Byte enables: base mask is B=1, H=11, W=1111, D=0xFF. It is shifted left by addr[log2(BE_W)-1:0].
- Write data: the data is replicated across all lanes: B x BE_W, H x BE_W/2, W x BE_W/4, D as-is.
- Load data:
  - Select lane = rdata >> (8*offset).
  - Sign-extend for B/H/W(64); zero-extend for BU/HU/WU.
  - W on XLEN=32 passes through.
- Reset mid-transaction: FSM to IDLE. A later data_rvalid_i or data_gnt_i in IDLE is ignored.

Decomposition:
- riscv_pkg gains:
  - LDST_D=3'b011 and LDST_WU=3'b110 alongside the existing LDST_* codes.
  - Enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - Cause constants LSU_EXC_MISALIGN=2'b01, LSU_EXC_ILLEGAL=2'b10, LSU_EXC_BUSERR=2'b11.
- One combinational sub-module, miriscv_lsu_align, parametrised by XLEN. It takes size, offset, wdata and rdata, and produces be, replicated wdata and extended rdata.

Test Plan:
- XLEN=32, SW addr 0x100, data 0xDEADBEEF, gnt in cycle 0, rvalid in cycle 1 -> be=1111, wdata=0xDEADBEEF, core_stall_o high exactly 2 cycles, no exception.
- LB/LBU addr 0x103, rdata 0x80FF0000 -> lsu_data_o 0xFFFFFF80 / 0x00000080, be=1000. LH/LHU addr 0x102, rdata 0x80011234 -> 0xFFFF8001 / 0x00008001.
- SH addr 0x101 -> no data_req_o, stall 1 cycle, lsu_exc_o=1 with cause 01. LD at XLEN=32 -> cause 10.
- gnt delayed 3 cycles, then rvalid after 2 more cycles with data_err_i=1 -> addr/be/wdata stable while req held, stall 6 cycles, cause 11, lsu_data_o=0.
- arstn_i low during WAIT, then rvalid arrives -> all outputs 0, FSM stays IDLE, the stale response is ignored, the next LW completes normally.
- XLEN=64, LD addr 0x8, rdata 0x0123456789ABCDEF -> be=0xFF, same data out. LW addr 0xC, rdata 0x80000000_00000000 -> be=0xF0, result 0xFFFFFFFF80000000. LWU -> 0x0000000080000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared load/store codes, LSU state and exception causes
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_D  = 3'b011;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;
  localparam logic [2:0] LDST_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [1:0] LSU_EXC_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_EXC_ILLEGAL  = 2'b10;
  localparam logic [1:0] LSU_EXC_BUSERR   = 2'b11;

endpackage

// File: rtl/miriscv_lsu_align.sv
// rtl/miriscv_lsu_align.sv - byte enables, store replication and load extension
module miriscv_lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int BE_W = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [2:0]       size_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [BE_W-1:0]  be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  rdata_o
);

  logic [BE_W-1:0] base_be;
  logic [XLEN-1:0] lane;

  always_comb begin
    base_be = '0;
    wdata_o = '0;
    case (size_i[1:0])
      2'b00: begin
        base_be = BE_W'(1);
        wdata_o = {BE_W{wdata_i[7:0]}};
      end
      2'b01: begin
        base_be = BE_W'(3);
        wdata_o = {(BE_W/2){wdata_i[15:0]}};
      end
      2'b10: begin
        base_be = BE_W'(4'hF);
        wdata_o = {(BE_W/4){wdata_i[31:0]}};
      end
      default: begin
        base_be = BE_W'(8'hFF);
        wdata_o = wdata_i;
      end
    endcase
    be_o = base_be << offset_i;
  end

  // Bring the addressed lane down to bit 0 before extending.
  always_comb begin
    lane    = rdata_i >> {offset_i, 3'b000};
    rdata_o = '0;
    case (size_i)
      LDST_B:  rdata_o = XLEN'($signed(lane[7:0]));
      LDST_H:  rdata_o = XLEN'($signed(lane[15:0]));
      LDST_W:  rdata_o = XLEN'($signed(lane[31:0]));
      LDST_D:  rdata_o = lane;
      LDST_BU: rdata_o = XLEN'(lane[7:0]);
      LDST_HU: rdata_o = XLEN'(lane[15:0]);
      LDST_WU: rdata_o = XLEN'(lane[31:0]);
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu_obi.sv
// rtl/miriscv_lsu_obi.sv - load/store unit with req/gnt/rvalid data memory port
module miriscv_lsu_obi
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  localparam int BE_W = XLEN / 8
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  output logic [XLEN-1:0]   lsu_data_o,
  output logic              core_stall_o,
  output logic              lsu_exc_o,
  output logic [1:0]        lsu_exc_cause_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  output logic              data_we_o,
  output logic [BE_W-1:0]   data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,
  input  logic              data_err_i
);

  localparam int OFF_W = $clog2(BE_W);

  lsu_state_t        state_q;
  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [OFF_W-1:0]  off_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   data_q;
  logic              exc_q;
  logic [1:0]        cause_q;

  logic              in_idle;
  logic              illegal;
  logic              misal;
  logic              start_ok;
  logic [ADDR_W-1:0] addr_al;
  logic [2:0]        al_size;
  logic [OFF_W-1:0]  al_off;
  logic [XLEN-1:0]   al_wdata;
  logic [BE_W-1:0]   al_be;
  logic [XLEN-1:0]   al_wdata_rep;
  logic [XLEN-1:0]   al_rdata;

  always_comb begin
    illegal = (lsu_size_i == 3'b111) ||
              ((XLEN == 32) && ((lsu_size_i == LDST_D) || (lsu_size_i == LDST_WU)));
    misal = 1'b0;
    case (lsu_size_i)
      LDST_H, LDST_HU: misal = lsu_addr_i[0];
      LDST_W, LDST_WU: misal = |lsu_addr_i[1:0];
      LDST_D:          misal = |lsu_addr_i[2:0];
      default:         misal = 1'b0;
    endcase
  end

  assign in_idle  = (state_q == IDLE);
  assign start_ok = in_idle && lsu_req_i && !illegal && !misal;
  assign addr_al  = {lsu_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};

  // The first request cycle comes straight from the core; later ones replay the latch.
  assign al_size  = in_idle ? lsu_size_i : size_q;
  assign al_off   = in_idle ? lsu_addr_i[OFF_W-1:0] : off_q;
  assign al_wdata = in_idle ? lsu_data_i : wdata_q;

  miriscv_lsu_align #(.XLEN(XLEN)) u_align (
    .size_i   (al_size),
    .offset_i (al_off),
    .wdata_i  (al_wdata),
    .rdata_i  (data_rdata_i),
    .be_o     (al_be),
    .wdata_o  (al_wdata_rep),
    .rdata_o  (al_rdata)
  );

  assign data_req_o   = start_ok || (state_q == REQ);
  assign data_addr_o  = data_req_o ? (in_idle ? addr_al : addr_q) : '0;
  assign data_we_o    = data_req_o && (in_idle ? lsu_we_i : we_q);
  assign data_be_o    = data_req_o ? al_be : '0;
  assign data_wdata_o = data_req_o ? al_wdata_rep : '0;

  assign core_stall_o    = in_idle ? lsu_req_i : (state_q != DONE);
  assign lsu_data_o      = data_q;
  assign lsu_exc_o       = exc_q;
  assign lsu_exc_cause_o = cause_q;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      exc_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            if (illegal || misal) begin
              data_q  <= '0;
              exc_q   <= 1'b1;
              cause_q <= illegal ? LSU_EXC_ILLEGAL : LSU_EXC_MISALIGN;
              state_q <= DONE;
            end else begin
              we_q    <= lsu_we_i;
              size_q  <= lsu_size_i;
              addr_q  <= addr_al;
              off_q   <= lsu_addr_i[OFF_W-1:0];
              wdata_q <= lsu_data_i;
              state_q <= data_gnt_i ? WAIT : REQ;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) state_q <= WAIT;
        end
        WAIT: begin
          if (data_rvalid_i) begin
            state_q <= DONE;
            if (data_err_i) begin
              data_q  <= '0;
              exc_q   <= 1'b1;
              cause_q <= LSU_EXC_BUSERR;
            end else begin
              data_q <= we_q ? '0 : al_rdata;
            end
          end
        end
        DONE: begin
          exc_q   <= 1'b0;
          cause_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu_obi.sv
// tb/tb_miriscv_lsu_obi.sv - scoreboard bench for 32- and 64-bit LSU instances
module tb_miriscv_lsu_obi;
  import riscv_pkg::*;

  typedef struct {
    bit          sel64;
    bit          we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          gd;
    int          rd;
    bit          err;
    logic [63:0] exp_data;
    logic [7:0]  exp_be;
    logic [31:0] exp_addr;
    logic [63:0] exp_wdata;
    bit          exp_exc;
    logic [1:0]  exp_cause;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    bit          exc;
    logic [1:0]  cause;
    int          stall;
  } res_t;

  logic        clk = 1'b0;
  logic        arstn;
  logic        sel64;
  logic        req, we, gnt, rvalid, err;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [63:0] wdata_in, rdata;

  logic [31:0] d32_data, d32_wdata, d32_addr;
  logic        d32_stall, d32_exc, d32_req, d32_we;
  logic [1:0]  d32_cause;
  logic [3:0]  d32_be;
  logic [63:0] d64_data, d64_wdata;
  logic [31:0] d64_addr;
  logic        d64_stall, d64_exc, d64_req, d64_we;
  logic [1:0]  d64_cause;
  logic [7:0]  d64_be;

  logic [63:0] o_data, o_wdata;
  logic [31:0] o_addr;
  logic [7:0]  o_be;
  logic [1:0]  o_cause;
  logic        o_stall, o_exc, o_req, o_we;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  miriscv_lsu_obi #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk_i(clk), .arstn_i(arstn),
    .lsu_req_i(req & ~sel64), .lsu_we_i(we), .lsu_size_i(size),
    .lsu_addr_i(addr), .lsu_data_i(wdata_in[31:0]),
    .lsu_data_o(d32_data), .core_stall_o(d32_stall),
    .lsu_exc_o(d32_exc), .lsu_exc_cause_o(d32_cause),
    .data_req_o(d32_req), .data_gnt_i(gnt & ~sel64), .data_we_o(d32_we),
    .data_be_o(d32_be), .data_addr_o(d32_addr), .data_wdata_o(d32_wdata),
    .data_rvalid_i(rvalid & ~sel64), .data_rdata_i(rdata[31:0]), .data_err_i(err)
  );

  miriscv_lsu_obi #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk_i(clk), .arstn_i(arstn),
    .lsu_req_i(req & sel64), .lsu_we_i(we), .lsu_size_i(size),
    .lsu_addr_i(addr), .lsu_data_i(wdata_in),
    .lsu_data_o(d64_data), .core_stall_o(d64_stall),
    .lsu_exc_o(d64_exc), .lsu_exc_cause_o(d64_cause),
    .data_req_o(d64_req), .data_gnt_i(gnt & sel64), .data_we_o(d64_we),
    .data_be_o(d64_be), .data_addr_o(d64_addr), .data_wdata_o(d64_wdata),
    .data_rvalid_i(rvalid & sel64), .data_rdata_i(rdata), .data_err_i(err)
  );

  assign o_data  = sel64 ? d64_data  : {32'b0, d32_data};
  assign o_wdata = sel64 ? d64_wdata : {32'b0, d32_wdata};
  assign o_addr  = sel64 ? d64_addr  : d32_addr;
  assign o_be    = sel64 ? d64_be    : {4'b0, d32_be};
  assign o_cause = sel64 ? d64_cause : d32_cause;
  assign o_stall = sel64 ? d64_stall : d32_stall;
  assign o_exc   = sel64 ? d64_exc   : d32_exc;
  assign o_req   = sel64 ? d64_req   : d32_req;
  assign o_we    = sel64 ? d64_we    : d32_we;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, {63'b0, o_stall}, 64'd0);
    check({tag, "_req"},   {63'b0, o_req},   64'd0);
    check({tag, "_data"},  o_data,           64'd0);
    check({tag, "_exc"},   {63'b0, o_exc},   64'd0);
    check({tag, "_cause"}, {62'b0, o_cause}, 64'd0);
    check({tag, "_be"},    {56'b0, o_be},    64'd0);
    check({tag, "_addr"},  {32'b0, o_addr},  64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    res_t r;
    int   stall_n;
    bit   done;
    bit   pre_exc;
    pre_exc = v.exp_exc && (v.exp_cause != LSU_EXC_BUSERR);
    exp_q.push_back('{v.exp_data, v.exp_exc, v.exp_cause, v.exp_stall});
    @(posedge clk); #1;
    sel64 = v.sel64; req = 1'b1; we = v.we; size = v.size; addr = v.addr;
    wdata_in = v.wdata; rdata = v.rdata;
    stall_n = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      gnt    = (cyc == v.gd) && !pre_exc;
      rvalid = (cyc == v.gd + v.rd) && !pre_exc;
      err    = rvalid && v.err;
      @(negedge clk);
      if (pre_exc) check("no_req", {63'b0, o_req}, 64'd0);
      if (o_req) begin
        check("addr", {32'b0, o_addr}, {32'b0, v.exp_addr});
        check("be",   {56'b0, o_be},   {56'b0, v.exp_be});
        check("we",   {63'b0, o_we},   {63'b0, v.we});
        if (v.we) check("wdata", o_wdata, v.exp_wdata);
      end
      if (o_stall) begin
        stall_n++;
      end else begin
        r = exp_q.pop_front();
        check("rdata", o_data, r.data);
        check("exc",   {63'b0, o_exc},   {63'b0, r.exc});
        check("cause", {62'b0, o_cause}, {62'b0, r.cause});
        check("stall", 64'(stall_n), 64'(r.stall));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      check("timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
    req = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
  endtask

  initial begin
    arstn = 1'b0; sel64 = 1'b0; req = 1'b0; we = 1'b0; size = '0; addr = '0;
    wdata_in = '0; rdata = '0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst32");
    sel64 = 1'b1;
    #1;
    check_idle_outputs("rst64");
    sel64 = 1'b0;
    @(posedge clk); #1;
    arstn = 1'b1;

    // sel64 we size addr wdata rdata gd rd err | data be addr wdata exc cause stall
    vecs.push_back('{0, 1, LDST_W,  32'h100, 64'hDEADBEEF, 64'h0, 0, 1, 0, 64'h0, 8'h0F, 32'h100, 64'hDEADBEEF, 0, 2'b00, 2});
    vecs.push_back('{0, 0, LDST_B,  32'h103, 64'h0, 64'h80FF0000, 0, 1, 0, 64'hFFFFFF80, 8'h08, 32'h100, 64'h0, 0, 2'b00, 2});
    vecs.push_back('{0, 0, LDST_BU, 32'h103, 64'h0, 64'h80FF0000, 0, 1, 0, 64'h00000080, 8'h08, 32'h100, 64'h0, 0, 2'b00, 2});
    vecs.push_back('{0, 0, LDST_H,  32'h102, 64'h0, 64'h80011234, 0, 1, 0, 64'hFFFF8001, 8'h0C, 32'h100, 64'h0, 0, 2'b00, 2});
    vecs.push_back('{0, 0, LDST_HU, 32'h102, 64'h0, 64'h80011234, 0, 1, 0, 64'h00008001, 8'h0C, 32'h100, 64'h0, 0, 2'b00, 2});
    vecs.push_back('{0, 1, LDST_B,  32'h102, 64'hA5, 64'h0, 0, 1, 0, 64'h0, 8'h04, 32'h100, 64'hA5A5A5A5, 0, 2'b00, 2});
    vecs.push_back('{0, 1, LDST_H,  32'h102, 64'h1234, 64'h0, 0, 1, 0, 64'h0, 8'h0C, 32'h100, 64'h12341234, 0, 2'b00, 2});
    vecs.push_back('{0, 1, LDST_H,  32'h101, 64'h1234, 64'h0, 0, 1, 0, 64'h0, 8'h00, 32'h0, 64'h0, 1, 2'b01, 1});
    vecs.push_back('{0, 0, LDST_D,  32'h100, 64'h0, 64'h0, 0, 1, 0, 64'h0, 8'h00, 32'h0, 64'h0, 1, 2'b10, 1});
    vecs.push_back('{0, 1, LDST_W,  32'h104, 64'hCAFEF00D, 64'h0, 3, 2, 1, 64'h0, 8'h0F, 32'h104, 64'hCAFEF00D, 1, 2'b11, 6});
    vecs.push_back('{0, 0, LDST_W,  32'h108, 64'h0, 64'h89ABCDEF, 1, 3, 0, 64'h89ABCDEF, 8'h0F, 32'h108, 64'h0, 0, 2'b00, 5});
    vecs.push_back('{1, 0, LDST_D,  32'h8, 64'h0, 64'h0123456789ABCDEF, 0, 1, 0, 64'h0123456789ABCDEF, 8'hFF, 32'h8, 64'h0, 0, 2'b00, 2});
    vecs.push_back('{1, 0, LDST_W,  32'hC, 64'h0, 64'h8000000000000000, 0, 1, 0, 64'hFFFFFFFF80000000, 8'hF0, 32'h8, 64'h0, 0, 2'b00, 2});
    vecs.push_back('{1, 0, LDST_WU, 32'hC, 64'h0, 64'h8000000000000000, 0, 1, 0, 64'h0000000080000000, 8'hF0, 32'h8, 64'h0, 0, 2'b00, 2});
    vecs.push_back('{1, 1, LDST_B,  32'h5, 64'h3C, 64'h0, 0, 1, 0, 64'h0, 8'h20, 32'h0, 64'h3C3C3C3C3C3C3C3C, 0, 2'b00, 2});
    vecs.push_back('{1, 1, LDST_W,  32'hC, 64'hDEADBEEF, 64'h0, 2, 1, 0, 64'h0, 8'hF0, 32'h8, 64'hDEADBEEFDEADBEEF, 0, 2'b00, 4});
    vecs.push_back('{1, 0, LDST_D,  32'h4, 64'h0, 64'h0, 0, 1, 0, 64'h0, 8'h00, 32'h0, 64'h0, 1, 2'b01, 1});
    vecs.push_back('{1, 0, 3'b111,  32'h0, 64'h0, 64'h0, 0, 1, 0, 64'h0, 8'h00, 32'h0, 64'h0, 1, 2'b10, 1});

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a load waits for its response; the stale rvalid must be dropped.
    @(posedge clk); #1;
    sel64 = 1'b0; req = 1'b1; we = 1'b0; size = LDST_W; addr = 32'h200; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0; req = 1'b0; arstn = 1'b0;
    @(posedge clk); #1;
    arstn = 1'b1; rvalid = 1'b1; rdata = 64'h11223344;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    @(posedge clk); #1;
    rvalid = 1'b0;
    @(negedge clk);
    check("stale_data",  o_data, 64'd0);
    check("stale_stall", {63'b0, o_stall}, 64'd0);
    run_vec('{0, 0, LDST_W, 32'h200, 64'h0, 64'h55AA55AA, 0, 1, 0, 64'h55AA55AA, 8'h0F, 32'h200, 64'h0, 0, 2'b00, 2});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
